// File: rtl/divider_iterative_if.sv
// Handshake and operand bundle between the EX-stage issue logic and divider_iterative.
interface divider_iterative_if #(
  parameter int XLEN = 32
);
  logic            startD;
  logic [1:0]      div_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [XLEN-1:0] result_divide;
  logic            done;
  logic            div_use;

  modport master (
    output startD, div_opcode, operand1, operand2,
    input  result_divide, done, div_use
  );

  modport slave (
    input  startD, div_opcode, operand1, operand2,
    output result_divide, done, div_use
  );
endinterface

// File: rtl/divider_iterative.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: |dividend| < |divisor| finishes on the 1-cycle special path.
module divider_iterative #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  divider_iterative_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]      state;
  logic            is_rem;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dsr;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Start decode: magnitudes, sign flags and the special-case fast path
  logic                   accept;
  logic                   is_signed;
  logic signed [XLEN-1:0] op1_s;
  logic signed [XLEN-1:0] op2_s;
  logic                   a_neg;
  logic                   b_neg;
  logic [XLEN-1:0]        a_mag;
  logic [XLEN-1:0]        b_mag;
  logic                   div_zero;
  logic                   ovf;
  logic                   early;
  logic                   sp;
  logic [XLEN-1:0]        sp_q;
  logic [XLEN-1:0]        sp_r;

  // A start arriving in the done cycle is dropped so the pipeline sees one clean release.
  assign accept    = (state == S_IDLE) && bus.startD && !done_q;
  assign is_signed = ~bus.div_opcode[0];
  assign op1_s     = bus.operand1;
  assign op2_s     = bus.operand2;
  assign a_neg     = is_signed && (op1_s < 0);
  assign b_neg     = is_signed && (op2_s < 0);
  assign a_mag     = neg_if(bus.operand1, a_neg);
  assign b_mag     = neg_if(bus.operand2, b_neg);
  assign div_zero  = (bus.operand2 == '0);
  assign ovf       = is_signed && (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.operand2 == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early     = !div_zero && (a_mag < b_mag);
`else
  assign early     = 1'b0;
`endif

  always_comb begin
    sp   = 1'b0;
    sp_q = '0;
    sp_r = '0;
    if (div_zero) begin
      sp   = 1'b1;
      sp_q = '1;
      sp_r = bus.operand1;
    end else if (ovf) begin
      sp   = 1'b1;
      sp_q = {1'b1, {(XLEN-1){1'b0}}};
      sp_r = '0;
    end else if (early) begin
      sp   = 1'b1;
      sp_q = '0;
      sp_r = bus.operand1;
    end
  end

  // Iteration: shift {rem, quo} left, trial-subtract the divisor XLEN+1 bits wide
  logic [XLEN:0]        rem_sh;
  logic signed [XLEN:0] trial;
  logic                 take;

  assign rem_sh = {rem, quo[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dsr};
  assign take   = ~trial[XLEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_rem <= bus.div_opcode[1];
            dsr    <= b_mag;
            cnt    <= '0;
            if (sp) begin
              quo   <= sp_q;
              rem   <= sp_r;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              state <= S_FIN;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem <= take ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo <= {quo[XLEN-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) state <= S_FIN;
        end
        S_FIN: begin
          result_q <= is_rem ? neg_if(rem, r_neg) : neg_if(quo, q_neg);
          done_q   <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.div_use       = accept || (state == S_CALC) || (state == S_FIN);
  assign bus.result_divide = result_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed table, handshake/reset sequences, random ops.
module tb_divider_iterative;
  localparam int XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  divider_iterative_if #(.XLEN(XLEN)) bus ();

  divider_iterative #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain integer arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    longint ma;
    longint mb;
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    ma = op[0] ? longint'(a) : (sa < 0 ? -longint'(sa) : longint'(sa));
    mb = op[0] ? longint'(b) : (sb < 0 ? -longint'(sb) : longint'(sb));
    if (EL == 1 && ma < mb) return 1;
    return 33;
  endfunction

  // Issue one operation at posedge+1, then watch 46 cycles for done pulses and stall length.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int restart_at, output logic [31:0] res, output int lat,
                        output int use_cnt, output int dones);
    bus.startD     = 1'b1;
    bus.div_opcode = op;
    bus.operand1   = a;
    bus.operand2   = b;
    #1;
    chk("div_use_at_start", 32'(bus.div_use), 32'd1);
    @(posedge clk);
    #1;
    bus.startD     = 1'b0;
    bus.div_opcode = 2'($urandom);
    bus.operand1   = $urandom;
    bus.operand2   = $urandom;
    res = '0;
    lat = 0;
    use_cnt = 0;
    dones = 0;
    for (int k = 0; k < 46; k++) begin
      if (bus.done) begin
        dones++;
        if (lat == 0) begin
          lat = k;
          res = bus.result_divide;
          chk("div_use_in_done", 32'(bus.div_use), 32'd0);
        end
      end else if (lat == 0 && bus.div_use) begin
        use_cnt++;
      end
      if (k == restart_at) begin
        bus.startD     = 1'b1;
        bus.div_opcode = 2'b11;
        bus.operand1   = 32'd5;
        bus.operand2   = 32'd3;
      end
      @(posedge clk);
      #1;
      bus.startD = 1'b0;
    end
    if (lat == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: no done within 46 cycles, expected one");
    end
  endtask

  vec_t        vecs[13];
  logic [31:0] res;
  int          lat;
  int          use_cnt;
  int          dones;
  logic [1:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;
  int          got_done;

  initial begin
    bus.startD     = 1'b0;
    bus.div_opcode = 2'b00;
    bus.operand1   = '0;
    bus.operand2   = '0;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
    vecs[3]  = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
    vecs[4]  = '{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          33};
    vecs[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[7]  = '{2'b01, 32'd1234,       32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{2'b10, 32'd1234,       32'd0,          32'd1234,       1};
    vecs[9]  = '{2'b00, 32'd1234,       32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{2'b01, 32'd3,          32'd10,         32'd0,          EL};
    vecs[11] = '{2'b11, 32'd3,          32'd10,         32'd3,          EL};
    vecs[12] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  33};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", bus.result_divide, 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_div_use", 32'(bus.div_use), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, use_cnt, dones);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_div_use_cycles", i), 32'(use_cnt), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_done_pulses", i), 32'(dones), 32'd1);
    end

    // Restart request mid-operation must be ignored
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 10, res, lat, use_cnt, dones);
    chk("restart_result", res, 32'hFFFF_FFFF);
    chk("restart_latency", 32'(lat), 32'd33);
    chk("restart_done_pulses", 32'(dones), 32'd1);

    // Start in the done cycle is dropped; re-issue next cycle works
    bus.startD = 1'b1; bus.div_opcode = 2'b01; bus.operand1 = 32'd100; bus.operand2 = 32'd7;
    @(posedge clk);
    #1;
    bus.startD = 1'b0;
    got_done = 0;
    for (int k = 0; k < 40 && got_done == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) got_done = 1;
    end
    chk("done_cycle_reached", 32'(got_done), 32'd1);
    bus.startD = 1'b1; bus.div_opcode = 2'b01; bus.operand1 = 32'd9; bus.operand2 = 32'd3;
    #1;
    chk("done_cycle_start_div_use", 32'(bus.div_use), 32'd0);
    @(posedge clk);
    #1;
    bus.startD = 1'b0;
    #1;
    chk("done_cycle_start_ignored", 32'(bus.div_use), 32'd0);
    chk("done_cycle_result_held", bus.result_divide, 32'd14);
    run_op(2'b01, 32'd9, 32'd3, -1, res, lat, use_cnt, dones);
    chk("reissue_result", res, 32'd3);

    // Reset mid-operation abandons it without a done pulse
    bus.startD = 1'b1; bus.div_opcode = 2'b01; bus.operand1 = 32'd1000; bus.operand2 = 32'd7;
    @(posedge clk);
    #1;
    bus.startD = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_reset_div_use", 32'(bus.div_use), 32'd1);
    rst = 1'b0;
    #1;
    chk("midop_reset_result", bus.result_divide, 32'd0);
    chk("midop_reset_done", 32'(bus.done), 32'd0);
    chk("midop_reset_div_use", 32'(bus.div_use), 32'd0);
    got_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) got_done = 1;
    end
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) got_done = 1;
    end
    chk("midop_reset_no_done", 32'(got_done), 32'd0);
    run_op(2'b11, 32'd100, 32'd7, -1, res, lat, use_cnt, dones);
    chk("post_reset_result", res, 32'd2);
    chk("post_reset_latency", 32'(lat), 32'd33);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       rb = ra + 32'($urandom_range(0, 3));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(rop, ra, rb, -1, res, lat, use_cnt, dones);
      chk($sformatf("rand%0d_op%0d_%h_%h_result", i, rop, ra, rb), res, ref_res(rop, ra, rb));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(rop, ra, rb)));
      chk($sformatf("rand%0d_done_pulses", i), 32'(dones), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/divider_iterative.md
Name: divider_iterative

Overview:
- Radix-2 restoring iterative divider implementing RV32M DIV, DIVU, REM and REMU.
- Companion to the iterative multiplier in the EX stage of the 5-stage pipeline, with the same start/done/busy handshake, so the hazard unit stalls on div_use exactly as it does on mul_use.
- One quotient bit per cycle.
- Special cases (divide-by-zero, signed overflow) resolve on a fast path.

Parameters:
XLEN, 32, operand/result width; the counter is clog2(XLEN)+1 bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- startD  input  1  start request, sampled only in IDLE.
- div_opcode  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0]).
- operand1  input  XLEN  dividend (rs1).
- operand2  input  XLEN  divisor (rs2).
- result_divide  output  XLEN  quotient or remainder; held until next accepted start.
- done  output  1  one-cycle pulse when result_divide is valid.
- div_use  output  1  busy/stall request to the hazard unit.

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; result_divide=0, done=0, div_use=0.
  - Internal quotient, remainder and counter registers cleared.
  - Any in-flight operation is abandoned with no done pulse.
- States: IDLE, CALC, FIN.
- IDLE, startD=1 at edge E0:
  - Latch the opcode.
  - Latch abs(operand1) and abs(operand2) for signed ops, raw values for unsigned ops.
  - Latch sign flags: q_neg = sign(op1) XOR sign(op2); r_neg = sign(op1) (signed ops only).
  - Remainder reg = 0; counter = 0.
  - Next state is CALC, unless a special case applies, in which case next state is FIN with the result preloaded.
- Special cases, detected at E0:
  - Divisor = 0: DIV/DIVU result = all-ones (0xFFFFFFFF); REM/REMU result = operand1.
  - DIV with operand1 = 0x80000000 and operand2 = 0xFFFFFFFF: result 0x80000000. REM with the same operands: result 0.
- CALC, one iteration per edge, XLEN edges (E1..E32):
  - Shift {rem, dvd} left by 1.
  - Trial = rem - divisor, computed XLEN+1 bits wide.
  - If trial is non-negative: rem = trial, quotient LSB = 1; otherwise quotient LSB = 0.
  - Counter increments; at counter = XLEN-1 the next state is FIN.
- FIN, one cycle:
  - Apply sign fix-up: quotient negated if q_neg; remainder negated if r_neg.
  - result_divide takes the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - done=1 for exactly this cycle; next state is IDLE.
- Latency:
  - Normal path: done high in the cycle after edge E33 (start to done = 33 cycles).
  - Special path: done high after edge E1 (start to done = 1 cycle).
- div_use:
  - Combinationally high when IDLE and startD=1.
  - Registered high throughout CALC.
  - Low in the done cycle, so the pipeline releases on done.
  - Low in IDLE otherwise.
- Handshake:
  - startD while in CALC or FIN is ignored and not queued.
  - startD in the same cycle as done (FIN) is ignored; it may be re-issued in the next cycle, which is IDLE.
  - Operand/opcode changes after E0 have no effect.
- result_divide holds its value until it is overwritten in the FIN of the next operation. It is not cleared on start.
- Remainder satisfies dividend = quotient*divisor + remainder, with the remainder sign matching the dividend (RISC-V semantics).

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- With macro defined: at E0, if the unsigned-magnitude dividend < magnitude divisor (and divisor != 0), take the special path.
  - Quotient 0; remainder = operand1 unchanged.
  - FIN at E1; done after 1 cycle.
- Without macro: such operands run the full 33-cycle path.
- Results are identical in both configurations; only latency differs.

Test Plan:
- DIVU 100/7 → done 33 cycles after start, result 14. REMU 100/7 → 2. div_use high for 33 cycles, low in the done cycle.
- DIV -100/7 (0xFFFFFF9C, 7) → 0xFFFFFFF2 (-14). REM -100/7 → 0xFFFFFFFE (-2). REM 100/-7 → 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with done after 1 cycle. REM with the same operands → 0.
- DIVU 1234/0 → 0xFFFFFFFF; REM 1234/0 → 1234. Both with done after 1 cycle.
- Pulse startD again at cycle 10 of a DIVU 0xFFFFFFFF/1 → ignored; result 0xFFFFFFFF, single done pulse. Assert rst=0 at cycle 20 of a second operation → outputs 0 immediately, no done pulse; the next start works normally.
- DIVU 3/10 → result 0. With DIV_EARLY_OUT_EN, done after 1 cycle; without it, after 33 cycles. REMU 3/10 → 3 in both configurations.
